osd_vram_arb: RTL

OSD_VRAM_ARB -- requirements
Module: osd_vram_arb

---
 rtl/osd_vram_arb.sv | 102 ++++++++++
 1 files changed

// File: rtl/osd_vram_arb.sv
// OSD VRAM write-port arbiter: host writes vs. a whole-VRAM fill engine, round robin per write slot.
// Latency: a grant in cycle t gives registered VRAM_WE_o (plus CPU_ACK_o or CLR_DONE_o) at t+1.
// Backpressure: requesters wait indefinitely outside write slots; the host holds CPU_REQ_i until CPU_ACK_o.
module osd_vram_arb #(
    parameter int C_VRAM_WORDS = 1024,
    parameter bit C_WAIT_BLANK = 1'b1
) (
    input  logic       CK_i,
    input  logic       XSYS_R_i,
    input  logic       BLANK_i,
    input  logic       CPU_REQ_i,
    input  logic [9:0] CPU_WAs_i,
    input  logic [7:0] CPU_WDs_i,
    output logic       CPU_ACK_o,
    input  logic       CLR_START_i,
    input  logic [7:0] CLR_CODEs_i,
    output logic       CLR_BUSY_o,
    output logic       CLR_DONE_o,
    output logic [9:0] VRAM_WAs_o,
    output logic [7:0] VRAM_WDs_o,
    output logic       VRAM_WE_o
);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    localparam logic [9:0] LAST_ADDR = 10'(C_VRAM_WORDS - 1);

    state_t     state, state_nxt;
    logic [9:0] cnt, cnt_nxt;
    logic [7:0] code, code_nxt;
    logic       last_cpu;
    logic       slot, cpu_pend, fill_pend;
    logic       grant_cpu, grant_fill, fill_last;

    // The ACK cycle masks the still-high request so one request gives exactly one write.
    always_comb begin
        slot       = (C_WAIT_BLANK == 1'b0) || BLANK_i;
        cpu_pend   = CPU_REQ_i && !CPU_ACK_o;
        fill_pend  = (state == S_FILL);
        grant_cpu  = slot && cpu_pend && (!fill_pend || !last_cpu);
        grant_fill = slot && fill_pend && !grant_cpu;
        fill_last  = grant_fill && (cnt == LAST_ADDR);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code;
        case (state)
            S_IDLE: begin
                if (CLR_START_i) begin
                    state_nxt = S_FILL;
                    cnt_nxt   = '0;
                    code_nxt  = CLR_CODEs_i;
                end
            end
            S_FILL: begin
                if (grant_fill) begin
                    cnt_nxt = cnt + 10'd1;
                    if (fill_last) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CK_i) begin
        if (!XSYS_R_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            code       <= '0;
            last_cpu   <= 1'b0;
            VRAM_WE_o  <= 1'b0;
            VRAM_WAs_o <= '0;
            VRAM_WDs_o <= '0;
            CPU_ACK_o  <= 1'b0;
            CLR_DONE_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            code       <= code_nxt;
            VRAM_WE_o  <= grant_cpu || grant_fill;
            CPU_ACK_o  <= grant_cpu;
            CLR_DONE_o <= fill_last;
            if (grant_cpu || grant_fill) begin
                last_cpu <= grant_cpu;
            end
            if (grant_cpu) begin
                VRAM_WAs_o <= CPU_WAs_i;
                VRAM_WDs_o <= CPU_WDs_i;
            end else if (grant_fill) begin
                VRAM_WAs_o <= cnt;
                VRAM_WDs_o <= code;
            end
        end
    end

    assign CLR_BUSY_o = (state == S_FILL);

endmodule
